// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-cycle IF/ID pipeline register and BOOT/RUN/HALTED control.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets instead of silently aligning them.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign_err
);

    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] inst_next, ipc_next, ipc4_next;
    logic        valid_next;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign imem_addr       = pc[9:2];
    assign halted          = (state == HALTED);

`ifdef FETCH_MISALIGN_CHK_EN
    logic err_q, err_next;
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        inst_next  = ifid_inst;
        ipc_next   = ifid_pc;
        ipc4_next  = ifid_pc4;
        valid_next = ifid_valid;
`ifdef FETCH_MISALIGN_CHK_EN
        err_next   = err_q;
`endif
        case (state)
            BOOT: begin
                pc_next    = RESET_PC;
                inst_next  = NOP_INST;
                valid_next = 1'b0;
                state_next = RUN;
            end
            RUN: begin
                // Bubbles only replace the instruction and valid bit; the PC fields keep their last value
                if (redirect) begin
                    inst_next  = NOP_INST;
                    valid_next = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        err_next   = 1'b1;
                        state_next = HALTED;
                    end else begin
                        pc_next = redirect_target;
                    end
`else
                    pc_next = redirect_target;
`endif
                end else if (flush) begin
                    inst_next  = NOP_INST;
                    valid_next = 1'b0;
                    if (!stall)
                        pc_next = pc_plus4;
                end else if (!stall) begin
                    inst_next  = imem_data;
                    ipc_next   = pc;
                    ipc4_next  = pc_plus4;
                    valid_next = 1'b1;
                    pc_next    = pc_plus4;
                    if (imem_data == EBREAK_INST)
                        state_next = HALTED;
                end
            end
            HALTED: begin
                inst_next  = NOP_INST;
                valid_next = 1'b0;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            ifid_inst  <= NOP_INST;
            ifid_pc    <= 32'h0;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ifid_inst  <= inst_next;
            ifid_pc    <= ipc_next;
            ifid_pc4   <= ipc4_next;
            ifid_valid <= valid_next;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_next;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model feeds a scoreboard queue, plus directed checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data, ifid_inst, ifid_pc, ifid_pc4;
    logic        ifid_valid, halted, misalign_err;

    logic [31:0] mem [256];
    assign imem_data = mem[imem_addr];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        err;
        logic [7:0]  addr;
    } exp_t;

    exp_t exp_q[$];

    int          m_state;
    logic [31:0] m_pc, m_inst, m_ipc, m_ipc4;
    logic        m_valid, m_err;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ifid_inst    (ifid_inst),
        .ifid_pc      (ifid_pc),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_state = 0;
        m_pc    = 32'h0;
        m_inst  = 32'h00000013;
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic modelStep(input logic s, input logic f, input logic r, input logic [31:0] rpc);
        logic [31:0] fetched;
        fetched = mem[m_pc[9:2]];
        if (m_state == 0) begin
            m_inst = 32'h00000013; m_valid = 1'b0; m_state = 1;
        end else if (m_state == 1) begin
            if (r) begin
                m_inst = 32'h00000013; m_valid = 1'b0;
                if (CHK_EN && rpc[1:0] != 2'b00) begin
                    m_err = 1'b1; m_state = 2;
                end else begin
                    m_pc = {rpc[31:2], 2'b00};
                end
            end else if (f) begin
                m_inst = 32'h00000013; m_valid = 1'b0;
                if (!s) m_pc = m_pc + 32'd4;
            end else if (!s) begin
                m_inst  = fetched;
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                if (fetched == 32'h00100073) m_state = 2;
            end
        end else begin
            m_inst = 32'h00000013; m_valid = 1'b0;
        end
        exp_q.push_back('{m_inst, m_ipc, m_ipc4, m_valid, (m_state == 2), m_err, m_pc[9:2]});
    endtask

    // Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge
    task automatic applyStimulus(input logic s, input logic f, input logic r, input logic [31:0] rpc);
        exp_t e;
        stall = s; flush = f; redirect = r; redirect_pc = rpc;
        modelStep(s, f, r, rpc);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput("sb_inst", ifid_inst, e.inst);
            checkOutput("sb_valid", 32'(ifid_valid), 32'(e.valid));
            if (e.valid) begin
                checkOutput("sb_pc", ifid_pc, e.pc);
                checkOutput("sb_pc4", ifid_pc4, e.pc4);
            end
            checkOutput("sb_halted", 32'(halted), 32'(e.halted));
            checkOutput("sb_err", 32'(misalign_err), 32'(e.err));
            checkOutput("sb_addr", 32'(imem_addr), 32'(e.addr));
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_inst", ifid_inst, 32'h00000013);
        checkOutput("rst_pc", ifid_pc, 32'h0);
        checkOutput("rst_pc4", ifid_pc4, 32'h0);
        checkOutput("rst_valid", 32'(ifid_valid), 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'h0);
        checkOutput("rst_err", 32'(misalign_err), 32'h0);
        checkOutput("rst_addr", 32'(imem_addr), 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("rst_hold_valid", 32'(ifid_valid), 32'h0);
        checkOutput("rst_hold_addr", 32'(imem_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] first_inst [4];
        first_inst[0] = 32'h00002083;
        first_inst[1] = 32'h00402103;
        first_inst[2] = 32'h000001b3;
        first_inst[3] = 32'h00000233;

        for (int i = 0; i < 256; i++) mem[i] = 32'h00000033 | (32'(i) << 7);
        mem[0] = 32'h00002083;
        mem[1] = 32'h00402103;
        mem[2] = 32'h000001b3;
        mem[3] = 32'h00000233;
        mem[4] = 32'h001181b3;
        mem[9] = 32'h00100073;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        doReset();

        // Boot bubble, then the first four sequential fetches
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("boot_valid", 32'(ifid_valid), 32'h0);
        checkOutput("boot_inst", ifid_inst, 32'h00000013);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 32'h0);
            checkOutput("run_pc", ifid_pc, 32'(i * 4));
            checkOutput("run_inst", ifid_inst, first_inst[i]);
            if (i == 0) begin
                checkOutput("first_pc4", ifid_pc4, 32'h4);
                checkOutput("first_valid", 32'(ifid_valid), 32'h1);
                checkOutput("first_addr", 32'(imem_addr), 32'h1);
            end
        end

        // Back to pc=8, then stall three cycles
        applyStimulus(0, 0, 1, 32'h8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 32'h0);
            checkOutput("stall_addr", 32'(imem_addr), 32'h2);
            checkOutput("stall_valid", 32'(ifid_valid), 32'h0);
        end
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("unstall_pc", ifid_pc, 32'h8);

        // Redirect wins over stall
        applyStimulus(1, 0, 1, 32'h10);
        checkOutput("redir_bubble", 32'(ifid_valid), 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("redir_inst", ifid_inst, 32'h001181b3);
        checkOutput("redir_pc", ifid_pc, 32'h10);

        // Flush alone advances, flush+stall holds, redirect beats flush
        applyStimulus(0, 1, 0, 32'h0);
        checkOutput("flush_addr", 32'(imem_addr), 32'h6);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("flush_stall_addr", 32'(imem_addr), 32'h6);
        applyStimulus(0, 1, 1, 32'h10);
        checkOutput("redir_flush_addr", 32'(imem_addr), 32'h4);

        // Run into the ebreak at 0x24
        for (int i = 0; i < 20 && m_state != 2; i++) applyStimulus(0, 0, 0, 32'h0);
        checkOutput("ebreak_inst", ifid_inst, 32'h00100073);
        checkOutput("ebreak_valid", 32'(ifid_valid), 32'h1);
        checkOutput("ebreak_pc", ifid_pc, 32'h24);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(i % 2 == 0), 32'h40);
            checkOutput("halt_flag", 32'(halted), 32'h1);
            checkOutput("halt_valid", 32'(ifid_valid), 32'h0);
            checkOutput("halt_addr", 32'(imem_addr), 32'h0A);
        end

        // Asynchronous reset out of HALTED, then misaligned redirect from pc=8
        doReset();
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("pre_mis_addr", 32'(imem_addr), 32'h2);
        applyStimulus(0, 0, 1, 32'h12);
`ifdef FETCH_MISALIGN_CHK_EN
        checkOutput("mis_err", 32'(misalign_err), 32'h1);
        checkOutput("mis_halted", 32'(halted), 32'h1);
        checkOutput("mis_addr", 32'(imem_addr), 32'h2);
        applyStimulus(0, 0, 1, 32'h20);
        checkOutput("mis_sticky", 32'(misalign_err), 32'h1);
`else
        checkOutput("mis_err", 32'(misalign_err), 32'h0);
        checkOutput("mis_halted", 32'(halted), 32'h0);
        checkOutput("mis_addr", 32'(imem_addr), 32'h4);
`endif

        // PC wrap-around at the top of the address space
        doReset();
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'hFFFFFFFC);
        checkOutput("wrap_addr_top", 32'(imem_addr), 32'hFF);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("wrap_pc", ifid_pc, 32'hFFFFFFFC);
        checkOutput("wrap_pc4", ifid_pc4, 32'h0);
        checkOutput("wrap_addr", 32'(imem_addr), 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("wrap_next_pc", ifid_pc, 32'h0);
        checkOutput("wrap_next_inst", ifid_inst, 32'h00002083);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
